dff_pipe: RTL
=============

# dff_pipe

Parametrised, elastic, multi-stage positive-edge register pipeline with a valid/ready handshake, synchronous reset, flush, and an occupancy counter. It generalises the single rising-edge D flip-flop to WIDTH bits and DEPTH stages. It keeps the 1-bit phase toggle as an explicit per-word tag, with an optional mode that adds the phase into the data. It sits between a producer and a consumer as a retiming/buffering stage.

## Interface
- WIDTH, 8, data bits per word (≥1)
- DEPTH, 4, number of register stages (≥1)
- ADD_PHASE, 0, 1: stored word = in_data + phase (mod 2^WIDTH); 0: stored word = in_data
- CW, $clog2(DEPTH+1), width of count (derived, not overridden)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  producer has a word
- in_ready  out  1  pipeline accepts a word this cycle
- in_data  in  WIDTH  input word
- out_valid  out  1  stage DEPTH-1 holds a word
- out_ready  in  1  consumer takes the word
- out_data  out  WIDTH  word in last stage
- out_phase  out  1  phase tag of word in last stage
- count  out  CW  number of valid stages, 0..DEPTH

## Operation
- Stages 0..DEPTH-1, each holding {valid, phase, data}. Stage 0 is the input and stage DEPTH-1 is the output.
- Stage k advances when it is valid and (k = DEPTH-1 ? out_ready : stage k+1 empty or advancing). This gives bubble collapse: words move forward into empty stages even while the output is stalled.
- in_ready = !flush && (stage 0 empty or advancing). Accept = in_valid && in_ready.
- Phase register p: 0 after reset or flush. On accept, the word is tagged with p and then p toggles. The 1st, 3rd, … accepted words carry phase 0; the 2nd, 4th, … carry phase 1.
- When ADD_PHASE=1, the stored data = in_data + p, truncated to WIDTH (8'hFF + 1 → 8'h00).
- Transfer out = out_valid && out_ready.
- count = popcount of stage valid bits, registered consistently with those bits.
- Data in invalid stages is don't-care, except after rst, where it must be 0.

## Timing
- Reset (rst=1 at an edge):
  - all valid bits 0, all data and phase 0, p=0
  - out_valid=0, out_data=0, out_phase=0, count=0
  - in_ready=0 while rst is asserted
  - rst overrides flush and any handshake in the same cycle
- Flush (flush=1 at an edge, rst=0):
  - all valid bits 0, p=0, count=0 on the next cycle
  - in_ready=0 that cycle, so no word is accepted
  - an out transfer in the flush cycle still completes; the consumer sees it
- Latency: a word accepted at edge t into an empty pipe with out_ready=1 appears with out_valid=1 after edge t+DEPTH-1, i.e. DEPTH cycles from in_valid to out_valid. DEPTH=1 means one register.
- Throughput: one word per cycle when out_ready is held high. Simultaneous accept and out transfer leave count unchanged.
- Full (count=DEPTH) with out_ready=0: in_ready=0.
- Full with out_ready=1: in_ready=1 in the same cycle, through a combinational path from out_ready to in_ready.
- Empty: out_valid=0; out_data holds its last value.
- Word held at the output under stall: out_data and out_phase are stable until transferred.
- Count rules per cycle:
  - accept without transfer: +1
  - transfer without accept: −1
  - both: 0
  - count never exceeds DEPTH and never underflows.

## Structure
- The package dff_pipe_pkg holds a phase-tagged word typedef/struct {phase, data} parametrised via WIDTH, and a count-width helper function.
- The sub-module dff_pipe_stage is one elastic stage: valid/phase/data registers, advance logic, rst/flush clear. The top generates DEPTH instances, the phase register, the optional adder, and the count logic.

## Test plan
- Reset: with rst=1 for 2 cycles and in_valid=1, in_ready, out_valid and count stay 0 and out_data=0. After release, the first accepted word has out_phase=0.
- Streaming, WIDTH=8, DEPTH=4, ADD_PHASE=0, out_ready=1: send 0x10..0x17 back to back. Outputs are 0x10..0x17 in order, the first on cycle 4, phases 0,1,0,1…, and count is steady at 4.
- Backpressure: hold out_ready=0 and send 6 words. Exactly 4 are accepted, count=4 and in_ready=0. Raise out_ready: the remaining 2 are accepted with no loss or duplication.
- ADD_PHASE=1: inputs 0xFF, 0xFF, 0x05, 0x05 produce outputs 0xFF, 0x00, 0x05, 0x06.
- Flush mid-stream: with 3 words resident, pulse flush. The next cycle shows count=0 and out_valid=0. The next accepted word has phase 0.
- Bubble collapse: accept words on cycles 0 and 2 with out_ready=0, then wait 3 cycles. count=2 and the words are in stages 3 and 2. A single out_ready cycle emits only the first word.

Source files
------------

// File: rtl/dff_pipe_pkg.sv
// Shared helpers for the elastic register pipeline.
// Stage words are laid out as {phase, data}; the struct itself lives in the top,
// where WIDTH is known.
package dff_pipe_pkg;

    // Bits needed to hold an occupancy of 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth < 32'd1) ? 32'd1 : unsigned'($clog2(depth + 32'd1));
    endfunction

    // Word stored in stage 0: the input, optionally offset by the phase tag.
    function automatic logic [63:0] tag_data(input logic [63:0] data, input logic phase,
                                             input bit add_phase);
        return add_phase ? data + 64'(phase) : data;
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One elastic pipeline stage: a valid flag plus a W-bit word register.
// The top decides when this stage loads from upstream and when it hands its word on.
module dff_pipe_stage #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic         advance,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_q;
    logic [W-1:0] word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q <= 1'b1;
            end else if (advance) begin
                valid_q <= 1'b0;
            end
            // The word only changes on a real load, so an emptied stage keeps its last value.
            if (load && !flush) begin
                word_q <= d;
            end
        end
    end

    assign valid = valid_q;
    assign q     = word_q;

endmodule

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake, flush,
// a per-word phase tag and an occupancy counter.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADD_PHASE = 0,
    localparam int unsigned CW       = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_phase,
    output logic [CW-1:0]    count
);

    typedef struct packed {
        logic             phase;
        logic [WIDTH-1:0] data;
    } word_t;

    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] stage_adv;
    logic [DEPTH-1:0] stage_load;
    word_t            stage_word [DEPTH];
    word_t            in_word;
    logic             accept;
    logic             xfer;
    logic             phase_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Ready ripples back from out_ready so words collapse into bubbles under a stall.
    always_comb begin : ready_chain
        logic nxt_ready;
        nxt_ready = out_ready;
        stage_adv = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            stage_adv[k] = stage_valid[k] && nxt_ready;
            nxt_ready    = !stage_valid[k] || stage_adv[k];
        end
        in_ready = !rst && !flush && nxt_ready;
        accept   = in_valid && in_ready;
        stage_load    = '0;
        stage_load[0] = accept;
        for (int k = 1; k < int'(DEPTH); k++) begin
            stage_load[k] = stage_adv[k-1];
        end
    end

    always_comb begin
        in_word.phase = phase_q;
        in_word.data  = WIDTH'(tag_data(64'(in_data), phase_q, ADD_PHASE != 0));
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        word_t stage_d;
        assign stage_d = (k == 0) ? in_word : stage_word[(k == 0) ? 0 : k - 1];

        dff_pipe_stage #(
            .W (WIDTH + 1)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .load    (stage_load[k]),
            .advance (stage_adv[k]),
            .d       (stage_d),
            .valid   (stage_valid[k]),
            .q       (stage_word[k])
        );
    end

    assign xfer = stage_adv[DEPTH-1];

    always_comb begin
        count_d = count_q;
        if (accept && !xfer) begin
            count_d = count_q + 1'b1;
        end else if (xfer && !accept) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            phase_q <= 1'b0;
            count_q <= '0;
        end else begin
            if (accept) begin
                phase_q <= ~phase_q;
            end
            count_q <= count_d;
        end
    end

    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_word[DEPTH-1].data;
    assign out_phase = stage_word[DEPTH-1].phase;
    assign count     = count_q;

endmodule
